mealy_frame_ctrl: RTL and testbench
===================================

# mealy_frame_ctrl

Frame-level controller for the team's 4-state Mealy pulse detector (x_in/y_out datapath, states S0–S3). It does three things:
- Arbitrates between two requesters that each submit a WIDTH-bit frame.
- Clears the detector, then streams the frame into it serially, MSB first.
- Counts the detector's y pulses and returns the count with the winning requester's ID over a valid/ready result port.

The detector instance stays outside this block; this block drives its reset and x input and observes its y output.

## Interface
- WIDTH, 8, frame length in bits (≥2)
- CNT_W, 4, result counter width; count saturates at 2^CNT_W−1
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 frame available
- req0_data  input  WIDTH  requester 0 frame
- req0_ready  output  1  requester 0 frame accepted this cycle
- req1_valid  input  1  requester 1 frame available
- req1_data  input  WIDTH  requester 1 frame
- req1_ready  output  1  requester 1 frame accepted this cycle
- dp_rstn  output  1  registered active-low reset to detector
- x_out  output  1  serial bit to detector x_in
- y_in  input  1  detector y_out (Mealy, combinational on x_out)
- res_valid  output  1  result available
- res_id  output  1  requester that owned the frame
- res_count  output  CNT_W  number of cycles with y_in=1 during SHIFT
- res_ready  input  1  result consumer ready

## Operation
- FSM states are IDLE, CLEAR, SHIFT and REPORT.
- **IDLE**
  - If any reqN_valid is high, pick a grant g and assert reqg_ready combinationally for that cycle only.
  - Load reqg_data into the shift register, latch res_id=g, zero the count and the bit counter, then go to CLEAR.
  - If no request is valid, remain in IDLE.
- **CLEAR**
  - dp_rstn=0 for exactly this cycle, which returns the detector to S0. Next state is SHIFT.
- **SHIFT**
  - x_out = shift register MSB. Each cycle:
    - If y_in=1, count increments, saturating.
    - Shift left by one and increment the bit counter.
  - After WIDTH SHIFT cycles, go to REPORT.
- **REPORT**
  - res_valid=1; res_id and res_count are held stable.
  - When res_ready=1, the result is transferred, last_grant is set to res_id, and the FSM returns to IDLE.
- **Arbitration (round-robin, default):** if both requesters are valid, grant the one that is not last_grant. If only one is valid, grant it.
- **Outside SHIFT:** x_out=0.
- **reqN_ready:** only ever high in IDLE, never high for both requesters, and never high in the same cycle as res_valid.
- **Requester withdrawal:** a requester may drop valid before it is granted; no state is affected.
- **Reset mid-operation:** the frame in flight is discarded, no result is produced, and the FSM restarts in IDLE.

## Timing
- **Reset values:**
  - state=IDLE, dp_rstn=0, x_out=0, res_valid=0, res_id=0, res_count=0.
  - req0_ready=0, req1_ready=0, last_grant=1, so requester 0 wins the first tie.
- **dp_rstn:** rises to 1 on the first clock edge after rstn deasserts. It is low only during CLEAR (and during reset).
- **Latency (accept in cycle T):**
  - CLEAR occupies T+1.
  - SHIFT occupies T+2 … T+WIDTH+1.
  - res_valid is high from T+WIDTH+2.
- **Throughput:** if res_ready is held high, the next accept occurs at T+WIDTH+3, giving a minimum frame period of WIDTH+3 cycles.
- **Counting:** y_in is sampled in the same cycle as the x_out it responds to. It is ignored outside SHIFT.
- **Back-pressure:** while res_valid is high and res_ready is low, all outputs hold and no new request is accepted.

## Configuration
- **MEALY_FRAME_CTRL_RR_EN**
  - Defined: round-robin arbitration, as described above.
  - Undefined: fixed priority, where requester 0 always wins ties. last_grant is still kept but does not influence the grant.
  - Port list and timing are identical in both cases.

## Test plan
Bench connects the real 4-state detector model. Detector behaviour:
- x=1 advances S0→S1→S2→S3→S1; x=0 holds the state.
- y=1 on (S2, x=1) or on (S3, x=0).

Scenarios:
- **Reset:** hold rstn=0 → all outputs at their reset values. Release → dp_rstn=1 after one edge, state IDLE.
- **Single frame:** req0 frame 8'b1111_0000, res_ready=1.
  - req0_ready for 1 cycle, then dp_rstn low 1 cycle.
  - res_valid 10 cycles after accept, with res_id=0 and res_count=1.
- **Frame 8'b1110_0000 on req1** → res_count=6, res_id=1. Frame 8'b0000_0000 → res_count=0.
- **Tie:** both requests valid continuously with RR_EN defined → grants alternate 0,1,0,1. Same stimulus with RR_EN undefined → grants 0,0,0,0.
- **Back-pressure:** res_ready held low for 5 cycles in REPORT → res_valid, res_id and res_count stable, req*_ready stay 0. Accept occurs the cycle after res_ready rises.
- **Reset mid-SHIFT:** rstn pulsed low at bit 4 → no res_valid. The next frame completes with the correct count from S0.

Source files
------------

// File: rtl/mealy_frame_ctrl.sv
// Frame controller for the 4-state Mealy pulse detector: arbitrates two requesters, clears
// and streams the frame MSB-first, counts y pulses. Define MEALY_FRAME_CTRL_RR_EN for round-robin ties.
module mealy_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             dp_rstn,
    output logic             x_out,
    input  logic             y_in,
    output logic             res_valid,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    input  logic             res_ready
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [BW-1:0]    bits, bits_next;
    logic [CNT_W-1:0] count, count_next;
    logic             id, id_next;
    logic             last_grant, last_grant_next;
    logic             dp_rstn_reg;
    logic             grant;
    logic             any_valid;

    // grant is only meaningful when any_valid is high
    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef MEALY_FRAME_CTRL_RR_EN
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = ~req0_valid;
`else
        grant = ~req0_valid;
`endif
    end

    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bits_next       = bits;
        count_next      = count;
        id_next         = id;
        last_grant_next = last_grant;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    shreg_next = grant ? req1_data : req0_data;
                    id_next    = grant;
                    count_next = '0;
                    bits_next  = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                // y_in responds combinationally to the bit currently on x_out
                if (y_in && (count != {CNT_W{1'b1}}))
                    count_next = count + 1'b1;
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
                bits_next  = bits + 1'b1;
                if (bits == BW'(WIDTH - 1))
                    state_next = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    last_grant_next = id;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            shreg       <= '0;
            bits        <= '0;
            count       <= '0;
            id          <= 1'b0;
            last_grant  <= 1'b1;
            dp_rstn_reg <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            bits        <= bits_next;
            count       <= count_next;
            id          <= id_next;
            last_grant  <= last_grant_next;
            // registered so the detector reset is low for exactly the CLEAR cycle
            dp_rstn_reg <= (state_next != CLEAR);
        end
    end

    assign dp_rstn   = dp_rstn_reg;
    assign x_out     = (state == SHIFT) & shreg[WIDTH-1];
    assign res_valid = (state == REPORT);
    assign res_id    = id;
    assign res_count = count;

endmodule

// File: tb/tb_mealy_frame_ctrl.sv
// Bench for mealy_frame_ctrl with the 4-state detector attached; expectations follow
// MEALY_FRAME_CTRL_RR_EN the same way the design does.
module tb_mealy_frame_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             dp_rstn, x_out, y_in;
    logic             res_valid, res_id, res_ready;
    logic [CNT_W-1:0] res_count;

    int n_cmp = 0;
    int n_err = 0;
    bit last_g = 1'b1;

    always #5 clk = ~clk;

    mealy_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .dp_rstn(dp_rstn), .x_out(x_out), .y_in(y_in),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count), .res_ready(res_ready)
    );

    // detector: x=1 walks S0->S1->S2->S3->S1, x=0 holds; y on (S2,x=1) or (S3,x=0)
    logic [1:0] det_st;
    always_ff @(posedge clk) begin
        if (!dp_rstn)
            det_st <= 2'd0;
        else if (x_out)
            det_st <= (det_st == 2'd3) ? 2'd1 : det_st + 2'd1;
    end
    assign y_in = (x_out && det_st == 2'd2) || (!x_out && det_st == 2'd3);

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // number of pulses from the count of ones seen since S0
    function automatic int ref_count(input logic [WIDTH-1:0] d);
        int ones = 0;
        int c = 0;
        int st;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            st = (ones == 0) ? 0 : ((ones - 1) % 3) + 1;
            if ((d[i] && st == 2) || (!d[i] && st == 3))
                c++;
            if (d[i])
                ones++;
        end
        return (c > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : c;
    endfunction

    function automatic bit ref_grant(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef MEALY_FRAME_CTRL_RR_EN
            return !last_g;
`else
            return 1'b0;
`endif
        end
        return !v0;
    endfunction

    task automatic noise(input bit keep);
        if (!keep) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
        end
        #1;
    endtask

    // Starts at a falling edge with the DUT idle; returns at the falling edge after the transfer.
    task automatic frame(input bit v0, input bit v1, input logic [WIDTH-1:0] d0,
                         input logic [WIDTH-1:0] d1, input int bp, input bit keep, input string tag);
        bit g;
        logic [WIDTH-1:0] d;
        int exp;
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
        res_ready  = (bp == 0);
        g   = ref_grant(v0, v1);
        d   = g ? d1 : d0;
        exp = ref_count(d);
        #1;
        check(tag, "accept_rdy0", req0_ready, !g);
        check(tag, "accept_rdy1", req1_ready, g);
        check(tag, "accept_res_valid", res_valid, 0);
        @(negedge clk);
        noise(keep);
        check(tag, "clear_dp_rstn", dp_rstn, 0);
        check(tag, "clear_x", x_out, 0);
        check(tag, "clear_rdy", req0_ready | req1_ready, 0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            noise(keep);
            check(tag, "shift_x", x_out, d[WIDTH-1-i]);
            check(tag, "shift_dp_rstn", dp_rstn, 1);
            check(tag, "shift_rdy", req0_ready | req1_ready, 0);
            check(tag, "shift_res_valid", res_valid, 0);
        end
        @(negedge clk);
        noise(keep);
        check(tag, "rep_valid", res_valid, 1);
        check(tag, "rep_id", res_id, g);
        check(tag, "rep_count", res_count, exp);
        check(tag, "rep_rdy", req0_ready | req1_ready, 0);
        for (int k = 1; k < bp; k++) begin
            @(negedge clk);
            noise(keep);
            check(tag, "bp_valid", res_valid, 1);
            check(tag, "bp_id", res_id, g);
            check(tag, "bp_count", res_count, exp);
            check(tag, "bp_rdy", req0_ready | req1_ready, 0);
            check(tag, "bp_x", x_out, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        last_g = g;
        $display("frame %s: grant=%0d data=%b bp=%0d count=%0d res_count=%0d", tag, g, d, bp, exp, res_count);
    endtask

    initial begin
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", "dp_rstn", dp_rstn, 0);
        check("reset", "x_out", x_out, 0);
        check("reset", "res_valid", res_valid, 0);
        check("reset", "res_id", res_id, 0);
        check("reset", "res_count", res_count, 0);
        check("reset", "rdy", {req0_ready, req1_ready}, 0);
        rstn = 1'b1;
        #1;
        check("release", "dp_rstn_before_edge", dp_rstn, 0);
        @(negedge clk);
        check("release", "dp_rstn_after_edge", dp_rstn, 1);
        check("release", "res_valid", res_valid, 0);

        frame(1, 0, 8'b1111_0000, 8'h00, 0, 0, "single");
        frame(0, 1, 8'h00, 8'b1110_0000, 0, 0, "req1");
        frame(1, 0, 8'b0000_0000, 8'h00, 5, 0, "zero_bp");

        // reset while the frame is in SHIFT bit 4
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'b1110_0111; res_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        last_g = 1'b1;
        check("midrst", "dp_rstn", dp_rstn, 0);
        check("midrst", "x_out", x_out, 0);
        check("midrst", "res_valid", res_valid, 0);
        check("midrst", "res_id", res_id, 0);
        check("midrst", "res_count", res_count, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("midrst", "no_result", res_valid, 0);
            check("midrst", "dp_rstn_idle", dp_rstn, 1);
        end
        $display("midrst: reset applied during SHIFT bit 4, idle for 14 cycles");

        for (int i = 0; i < 4; i++)
            frame(1, 1, 8'($urandom), 8'($urandom), 0, 1, "tie");
        frame(0, 1, 8'h00, 8'b1110_0000, 0, 0, "after_rst");

        for (int i = 0; i < 20; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            frame(v0, v1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
